// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, regfile write-port and scoreboard signals shared by the
// regfile_wb_arbiter and its environment.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic                      stall_i;
  logic                      busy_set_i;
  logic [ADDR_W-1:0]         busy_addr_i;
  logic                      rd_wren_o;
  logic [ADDR_W-1:0]         rd_addr_o;
  logic [DATA_W-1:0]         rd_data_o;
  logic [GID_W-1:0]          grant_id_o;
  logic [(2**ADDR_W)-1:0]    busy_o;
  logic                      init_done_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, stall_i, busy_set_i, busy_addr_i,
    output req_ready_o, rd_wren_o, rd_addr_o, rd_data_o, grant_id_o, busy_o, init_done_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, stall_i, busy_set_i, busy_addr_i,
    input  req_ready_o, rd_wren_o, rd_addr_o, rd_data_o, grant_id_o, busy_o, init_done_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port with a pending-write scoreboard.
// Define RF_INIT_CLEAR_EN to add a post-reset sequencer that zeroes every register.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int NREG  = 2**ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef RF_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
  logic [ADDR_W:0] cnt_q;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t             state_q, state_d;
  logic [GID_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] ready;
  logic [GID_W-1:0]   gnt_idx;
  logic [GID_W:0]     scan_idx;
  logic               gnt_any;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic [NREG-1:0]    busy_q, busy_d;

  logic               wren_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [GID_W-1:0]   gid_p1;

  always_comb begin
    state_d = state_q;
`ifdef RF_INIT_CLEAR_EN
    if (state_q == ST_INIT && !bus.stall_i && cnt_q == {1'b0, {ADDR_W{1'b1}}})
      state_d = ST_RUN;
`endif
  end

  // Grant: scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    ready    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (state_q == ST_RUN && !bus.stall_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, ptr_q} + (GID_W+1)'(k);
        if (scan_idx >= (GID_W+1)'(NUM_REQ))
          scan_idx = scan_idx - (GID_W+1)'(NUM_REQ);
        if (!gnt_any && bus.req_valid_i[scan_idx[GID_W-1:0]]) begin
          gnt_any                       = 1'b1;
          gnt_idx                       = scan_idx[GID_W-1:0];
          ready[scan_idx[GID_W-1:0]]    = 1'b1;
        end
      end
    end
  end

  assign acc_addr = bus.req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign acc_data = bus.req_data_i[gnt_idx*DATA_W +: DATA_W];

  // New reservation wins over a same-cycle clear; x0 never reserved.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any)
      busy_d[acc_addr] = 1'b0;
    if (bus.busy_set_i)
      busy_d[bus.busy_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Stage p0 -> p1: accepted request becomes the registered regfile write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      busy_q  <= '0;
      wren_p1 <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      gid_p1  <= '0;
`ifdef RF_INIT_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
`ifdef RF_INIT_CLEAR_EN
      if (state_q == ST_INIT) begin
        if (!bus.stall_i) begin
          wren_p1 <= 1'b1;
          addr_p1 <= cnt_q[ADDR_W-1:0];
          data_p1 <= '0;
          cnt_q   <= cnt_q + 1'b1;
        end else begin
          wren_p1 <= 1'b0;
        end
      end else
`endif
      if (gnt_any) begin
        wren_p1 <= (acc_addr != '0);
        addr_p1 <= acc_addr;
        data_p1 <= acc_data;
        gid_p1  <= gnt_idx;
        ptr_q   <= (gnt_idx == GID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        wren_p1 <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rd_wren_o   = wren_p1;
  assign bus.rd_addr_o   = addr_p1;
  assign bus.rd_data_o   = data_p1;
  assign bus.grant_id_o  = gid_p1;
  assign bus.busy_o      = busy_q;
`ifdef RF_INIT_CLEAR_EN
  assign bus.init_done_o = (state_q == ST_RUN);
`else
  assign bus.init_done_o = 1'b1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle-level reference model plus directed vectors
// with literal expectations. Honours RF_INIT_CLEAR_EN when defined.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 1'b0;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
`ifdef RF_INIT_CLEAR_EN
  localparam bit INIT_AT_RESET = 1'b1;
`else
  localparam bit INIT_AT_RESET = 1'b0;
`endif
  bit          m_init;
  int          m_cnt;
  int          m_ptr;
  logic        m_wren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_gid;
  logic [31:0] m_busy;

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input bit in_init, input logic st,
                                             input int p, input logic [N-1:0] v);
    int g;
    logic [N-1:0] r;
    r = '0;
    if (!in_init && !st) begin
      g = pick(p, v);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int g;
    logic [AW-1:0] a;
    logic [31:0] nb;
    if (rst) begin
      m_init <= INIT_AT_RESET;
      m_cnt  <= 0;
      m_ptr  <= 0;
      m_wren <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_gid  <= 0;
      m_busy <= '0;
    end else begin
      nb = m_busy;
      g  = -1;
      if (m_init) begin
        if (!bus.stall_i) begin
          m_wren <= 1'b1;
          m_addr <= AW'(m_cnt);
          m_data <= '0;
          m_cnt  <= m_cnt + 1;
          if (m_cnt == 31) m_init <= 1'b0;
        end else begin
          m_wren <= 1'b0;
        end
      end else begin
        if (!bus.stall_i) g = pick(m_ptr, bus.req_valid_i);
        if (g >= 0) begin
          a = bus.req_addr_i[g*AW +: AW];
          m_wren <= (a != 0);
          m_addr <= a;
          m_data <= bus.req_data_i[g*DW +: DW];
          m_gid  <= g;
          m_ptr  <= (g + 1) % N;
          nb[a] = 1'b0;
        end else begin
          m_wren <= 1'b0;
        end
      end
      if (bus.busy_set_i && bus.busy_addr_i != 0) nb[bus.busy_addr_i] = 1'b1;
      m_busy <= nb;
    end
  end

  // Compare process: every falling edge once the bench is running
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_ready", bus.req_ready_o, exp_ready(m_init, bus.stall_i, m_ptr, bus.req_valid_i));
      chk("m_wren",  bus.rd_wren_o,   m_wren);
      chk("m_addr",  bus.rd_addr_o,   m_addr);
      chk("m_data",  bus.rd_data_o,   m_data);
      chk("m_gid",   bus.grant_id_o,  m_gid);
      chk("m_busy",  bus.busy_o,      m_busy);
      chk("m_idone", bus.init_done_o, !m_init);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_init();
    int nwr;
    nwr = 0;
    chk("init_done_low", bus.init_done_o, 1'b0);
    for (int i = 0; i < 34; i++) begin
      bus.stall_i = (i == 10 || i == 11);
      step();
      if (bus.rd_wren_o) begin
        chk("init_addr", bus.rd_addr_o, nwr);
        chk("init_data", bus.rd_data_o, 0);
        nwr++;
      end
      if (i == 32) chk("init_done_pre", bus.init_done_o, 1'b0);
    end
    bus.stall_i = 1'b0;
    chk("init_writes", nwr, 32);
    chk("init_done_hi", bus.init_done_o, 1'b1);
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_addr_i  = {5'd7, 5'd6, 5'd5};
    bus.req_data_i  = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
    bus.stall_i     = 1'b0;
    bus.busy_set_i  = 1'b0;
    bus.busy_addr_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wren", bus.rd_wren_o, 0);
    chk("rst_addr", bus.rd_addr_o, 0);
    chk("rst_data", bus.rd_data_o, 0);
    chk("rst_gid",  bus.grant_id_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    cmp_on = 1'b1;
    rst = 1'b0;

`ifdef RF_INIT_CLEAR_EN
    run_init();
`else
    chk("init_done_tied", bus.init_done_o, 1'b1);
`endif

    // All three valid: strict rotation 0,1,2,0,1,2
    bus.req_valid_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("rr_ready", bus.req_ready_o, 3'b001 << (k % 3));
      step();
      chk("rr_gid",  bus.grant_id_o, k % 3);
      chk("rr_addr", bus.rd_addr_o, 5 + (k % 3));
      chk("rr_wren", bus.rd_wren_o, 1'b1);
    end
    bus.req_valid_i = '0;
    step();
    chk("idle_wren", bus.rd_wren_o, 1'b0);
    chk("hold_addr", bus.rd_addr_o, 7);

    // Address-0 write from req1: accepted but never enabled
    bus.req_addr_i  = {5'd7, 5'd0, 5'd5};
    bus.req_data_i[DW +: DW] = 32'hDEAD_BEEF;
    bus.req_valid_i = 3'b010;
    #2;
    chk("x0_ready", bus.req_ready_o, 3'b010);
    step();
    bus.req_valid_i = '0;
    chk("x0_wren", bus.rd_wren_o, 1'b0);
    chk("x0_gid",  bus.grant_id_o, 1);
    chk("x0_data", bus.rd_data_o, 32'hDEAD_BEEF);
    bus.req_addr_i  = {5'd7, 5'd6, 5'd5};
    bus.req_valid_i = 3'b111;
    #2;
    chk("ptr_after_x0", bus.req_ready_o, 3'b100);
    bus.req_valid_i = 3'b001;

    // Stall three cycles with req0 pending
    bus.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", bus.req_ready_o, 3'b000);
      step();
      chk("stall_wren", bus.rd_wren_o, 1'b0);
    end
    bus.stall_i = 1'b0;
    #1;
    chk("unstall_ready", bus.req_ready_o, 3'b001);
    step();
    bus.req_valid_i = '0;
    chk("unstall_wren", bus.rd_wren_o, 1'b1);
    chk("unstall_addr", bus.rd_addr_o, 5);
    chk("unstall_gid",  bus.grant_id_o, 0);

    // Scoreboard set, clear, same-cycle set+clear, x0
    bus.busy_set_i = 1'b1; bus.busy_addr_i = 5'd9;
    step();
    bus.busy_set_i = 1'b0;
    chk("sb_set9", bus.busy_o[9], 1'b1);
    bus.req_addr_i  = {5'd7, 5'd6, 5'd9};
    bus.req_data_i[0 +: DW] = 32'h0000_0099;
    bus.req_valid_i = 3'b001;
    step();
    bus.req_valid_i = '0;
    chk("sb_clr9", bus.busy_o[9], 1'b0);
    chk("sb_wr9",  bus.rd_addr_o, 9);
    bus.busy_set_i = 1'b1; bus.busy_addr_i = 5'd9;
    bus.req_valid_i = 3'b001;
    step();
    bus.req_valid_i = '0;
    bus.busy_addr_i = 5'd0;
    chk("sb_setclr9", bus.busy_o[9], 1'b1);
    step();
    bus.busy_set_i = 1'b0;
    chk("sb_x0", bus.busy_o[0], 1'b0);
    chk("sb_keep9", bus.busy_o[9], 1'b1);

    // Reset in the middle of a write burst
    bus.req_addr_i  = {5'd7, 5'd6, 5'd5};
    bus.req_valid_i = 3'b111;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wren", bus.rd_wren_o, 1'b0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_gid",  bus.grant_id_o, 0);
    step();
    rst = 1'b0;
    #1;
`ifdef RF_INIT_CLEAR_EN
    chk("mid_rst_ready", bus.req_ready_o, 3'b000);
    bus.req_valid_i = '0;
    run_init();
    bus.req_valid_i = 3'b111;
    #1;
`endif
    chk("mid_rst_ptr", bus.req_ready_o, 3'b001);
    step();
    bus.req_valid_i = '0;
    chk("post_rst_gid", bus.grant_id_o, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
